// File: rtl/ddr_rd_tile_buf.sv
// Read-side tile buffer: per-channel FIFOs of wide DDR words are unpacked into a single
// raster-ordered pixel stream. Each pixel comes from the channel whose mosaic tile covers (row, col).
module ddr_rd_tile_buf #(
   parameter int DQ_WIDTH   = 32,
   parameter int PIX_WIDTH  = 16,
   parameter int H_WIDTH    = 1280,
   parameter int H_HEIGHT   = 720,
   parameter int GRID_COLS  = 2,
   parameter int GRID_ROWS  = 2,
   parameter int CH_NUM     = GRID_COLS*GRID_ROWS,
   parameter int FIFO_DEPTH = 64,
   parameter int AFULL_TH   = 56
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CH_NUM-1:0]            wr_en,
   input  logic [CH_NUM*DQ_WIDTH*8-1:0] wr_data,
   output logic [CH_NUM-1:0]            wr_full,
   output logic [CH_NUM-1:0]            wr_afull,
   output logic [CH_NUM-1:0]            overflow,
   input  logic                         rd_fsync,
   input  logic                         rd_en,
   output logic                         de_o,
   output logic [PIX_WIDTH-1:0]         pix_out,
   output logic [$clog2(CH_NUM)-1:0]    ch_id_o,
   output logic                         underflow
);

   localparam int WW     = DQ_WIDTH*8;
   localparam int PPW    = WW/PIX_WIDTH;
   localparam int TILE_W = H_WIDTH/GRID_COLS;
   localparam int TILE_H = H_HEIGHT/GRID_ROWS;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int AW1    = AW+1;
   localparam int CHW    = $clog2(CH_NUM);
   localparam int PW     = (PPW > 1)       ? $clog2(PPW)       : 1;
   localparam int TXW    = (TILE_W > 1)    ? $clog2(TILE_W)    : 1;
   localparam int TYW    = (TILE_H > 1)    ? $clog2(TILE_H)    : 1;
   localparam int GXW    = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
   localparam int GYW    = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;

   localparam logic [AW:0]    DEPTH_C  = AW1'(FIFO_DEPTH);
   localparam logic [AW:0]    AFULL_C  = AW1'(AFULL_TH);
   localparam logic [PW-1:0]  PIX_LAST = PW'(PPW-1);
   localparam logic [TXW-1:0] TX_LAST  = TXW'(TILE_W-1);
   localparam logic [TYW-1:0] TY_LAST  = TYW'(TILE_H-1);
   localparam logic [GXW-1:0] GX_LAST  = GXW'(GRID_COLS-1);
   localparam logic [GYW-1:0] GY_LAST  = GYW'(GRID_ROWS-1);

   logic [CH_NUM-1:0][AW:0]   wptr, rptr, cnt;
   logic [CH_NUM-1:0][PW-1:0] pidx, pidx_e;
   logic [CH_NUM-1:0][WW-1:0] head;
   logic [CH_NUM-1:0]         empty, full, push, pop, drop;

   // Raster position is held as (tile, offset-in-tile) pairs so the active channel needs no divider.
   logic [TXW-1:0] tx, tx_e, tx_n;
   logic [GXW-1:0] gx, gx_e, gx_n;
   logic [TYW-1:0] ty, ty_e, ty_n;
   logic [GYW-1:0] gy, gy_e, gy_n;

   logic [CHW-1:0]       ach;
   logic [WW-1:0]        head_w;
   logic [PW-1:0]        sel_pidx;
   logic [PIX_WIDTH-1:0] sel_pix;
   logic                 ach_empty;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      logic [WW-1:0] mem [FIFO_DEPTH];

      always_ff @(posedge clk) begin
         if (push[g]) mem[wptr[g][AW-1:0]] <= wr_data[g*WW +: WW];
      end

      assign head[g] = mem[rptr[g][AW-1:0]];
   end

   // A frame-sync request is served as if the position and all pixel indices were already zero.
   always_comb begin
      tx_e = rd_fsync ? '0 : tx;
      gx_e = rd_fsync ? '0 : gx;
      ty_e = rd_fsync ? '0 : ty;
      gy_e = rd_fsync ? '0 : gy;
      ach  = CHW'(int'(gy_e)*GRID_COLS + int'(gx_e));
      tx_n = tx_e;
      gx_n = gx_e;
      ty_n = ty_e;
      gy_n = gy_e;
      if (rd_en) begin
         if (tx_e != TX_LAST) tx_n = tx_e + 1'b1;
         else begin
            tx_n = '0;
            if (gx_e != GX_LAST) gx_n = gx_e + 1'b1;
            else begin
               gx_n = '0;
               if (ty_e != TY_LAST) ty_n = ty_e + 1'b1;
               else begin
                  ty_n = '0;
                  gy_n = (gy_e == GY_LAST) ? '0 : gy_e + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      cnt      = '0;
      pidx_e   = '0;
      empty    = '0;
      full     = '0;
      pop      = '0;
      push     = '0;
      drop     = '0;
      wr_full  = '0;
      wr_afull = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         cnt[c]      = wptr[c] - rptr[c];
         pidx_e[c]   = rd_fsync ? '0 : pidx[c];
         empty[c]    = (cnt[c] == '0);
         full[c]     = (cnt[c] == DEPTH_C);
         pop[c]      = rd_en && (ach == CHW'(c)) && (pidx_e[c] == PIX_LAST) && !empty[c];
         push[c]     = wr_en[c] && (!full[c] || pop[c]);
         drop[c]     = wr_en[c] && !push[c];
         wr_full[c]  = full[c];
         wr_afull[c] = (cnt[c] >= AFULL_C);
      end
      ach_empty = empty[ach];
      head_w    = head[ach];
      sel_pidx  = pidx_e[ach];
      sel_pix   = head_w[sel_pidx*PIX_WIDTH +: PIX_WIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         pidx      <= '0;
         tx        <= '0;
         gx        <= '0;
         ty        <= '0;
         gy        <= '0;
         de_o      <= 1'b0;
         pix_out   <= '0;
         ch_id_o   <= '0;
         underflow <= 1'b0;
         overflow  <= '0;
      end else begin
         for (int c = 0; c < CH_NUM; c++) begin
            if (push[c]) wptr[c] <= wptr[c] + 1'b1;
            if (pop[c])  rptr[c] <= rptr[c] + 1'b1;
            if (rd_en && (ach == CHW'(c)))
               pidx[c] <= (pidx_e[c] == PIX_LAST) ? '0 : pidx_e[c] + 1'b1;
            else
               pidx[c] <= pidx_e[c];
         end
         tx   <= tx_n;
         gx   <= gx_n;
         ty   <= ty_n;
         gy   <= gy_n;
         de_o <= rd_en;
         if (rd_en) begin
            pix_out <= ach_empty ? '0 : sel_pix;
            ch_id_o <= ach;
         end
         underflow <= (underflow && !rd_fsync) || (rd_en && ach_empty);
         overflow  <= (rd_fsync ? '0 : overflow) | drop;
      end
   end

endmodule
